// File: rtl/mips_cpu_div_iter.sv
// Iterative restoring divider for the MIPS DIV/DIVU path: magnitudes in, sign-corrected
// quotient (LO) and remainder (HI) out, with a one-edge fast path for divide-by-zero.
module mips_cpu_div_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic [CW-1:0]    cnt;
    logic             negq, negr, zdiv;

    logic [WIDTH-1:0] acc_next, prem_next;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? FIN : ITER;
            ITER: if (cnt == CW'(N - 1)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: blocking assignments here are intentional -- each unrolled step must see the
    // remainder produced by the previous step within the same cycle.
    always_comb begin
        trial     = '0;
        prem_next = prem;
        acc_next  = acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            trial    = {prem_next, acc_next[WIDTH-1]};
            acc_next = {acc_next[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dsr}) begin
                trial       = trial - {1'b0, dsr};
                acc_next[0] = 1'b1;
            end
            prem_next = trial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            acc       <= '0;
            dsr       <= '0;
            prem      <= '0;
            cnt       <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            zdiv      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        dbz  <= 1'b0;
                        zdiv <= (divisor == '0);
                        // The zero-divisor path must return the raw dividend, so skip the magnitude.
                        acc  <= (divisor == '0) ? dividend : mag(dividend, sign);
                        dsr  <= mag(divisor, sign);
                        negq <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr <= sign & dividend[WIDTH-1];
                        prem <= '0;
                        cnt  <= '0;
                    end
                end
                ITER: begin
                    acc  <= acc_next;
                    prem <= prem_next;
                    cnt  <= cnt + 1'b1;
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (zdiv) begin
                        quotient  <= '1;
                        remainder <= acc;
                        dbz       <= 1'b1;
                    end else begin
                        quotient  <= negq ? -acc  : acc;
                        remainder <= negr ? -prem : prem;
                        dbz       <= 1'b0;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule
